uart_tx_fifo: RTL and testbench



---
 rtl/uart_pkg.sv | 12 +
 rtl/uart_tx_fifo_if.sv | 8 +
 rtl/uart_sync_fifo.sv | 44 ++++
 rtl/uart_tx_fifo.sv | 110 +++++++++++
 tb/tb_uart_tx_fifo.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART FSM encoding, parity modes and clog2 helper
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_e;
  localparam logic [1:0] PAR_NONE = 2'd0;
  localparam logic [1:0] PAR_ODD = 2'd1;
  localparam logic [1:0] PAR_EVEN = 2'd2;
  function automatic int clog2(input int v);
    int r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/uart_tx_fifo_if.sv
// uart_tx_fifo_if: valid/ready word handshake into the transmitter FIFO
interface uart_tx_fifo_if #(parameter int DATA_BIT = 8);
  logic [DATA_BIT-1:0] i_data;
  logic                i_valid;
  logic                o_ready;
  modport master (output i_data, output i_valid, input o_ready);
  modport slave (input i_data, input i_valid, output o_ready);
endinterface

// File: rtl/uart_sync_fifo.sv
// uart_sync_fifo: single-clock FIFO with push/pop/full/empty/level
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [WIDTH-1:0]      i_data,
  output logic [WIDTH-1:0]      o_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [clog2(DEPTH):0] o_level
);
  localparam int AW = clog2(DEPTH);
  localparam int LW = AW + 1;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [LW-1:0] level_q;
  logic do_push, do_pop;
  // a full FIFO refuses pushes even when a pop lands on the same edge
  assign do_push = i_push && !o_full;
  assign do_pop = i_pop && !o_empty;
  assign o_full = level_q == LW'(DEPTH);
  assign o_empty = level_q == '0;
  assign o_level = level_q;
  assign o_data = mem_q[rd_q];
  always_ff @(posedge i_clk)
    if (do_push) mem_q[wr_q] <= i_data;
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wr_q <= '0;
      rd_q <= '0;
      level_q <= '0;
    end else begin
      wr_q <= wr_q + AW'(do_push);
      rd_q <= rd_q + AW'(do_pop);
      level_q <= level_q + LW'(do_push) - LW'(do_pop);
    end
  end
endmodule

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter with per-frame baud divisor and parity
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_BIT = 8,
  parameter int STOP_BIT = 1,
  parameter int FIFO_DEPTH = 16,
  parameter int DIV_WD = 16
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  uart_tx_fifo_if.slave              s,
  input  logic [DIV_WD-1:0]          i_div,
  input  logic [1:0]                 i_parity,
  output logic                       o_txd,
  output logic                       o_busy,
  output logic [clog2(FIFO_DEPTH):0] o_level
);
  localparam int BW = clog2(DATA_BIT + 1);
  state_e state_q, state_d;
  logic [DIV_WD-1:0] baud_q, baud_d, div_q, div_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [DATA_BIT-1:0] shift_q, shift_d, fifo_data;
  logic [1:0] par_q, par_d;
  logic pbit_q, pbit_d, txd_q, txd_d, busy_q;
  logic pop, full, empty, bit_end, parity_on;
  uart_sync_fifo #(.WIDTH(DATA_BIT), .DEPTH(FIFO_DEPTH)) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (s.i_valid),
    .i_pop   (pop),
    .i_data  (s.i_data),
    .o_data  (fifo_data),
    .o_full  (full),
    .o_empty (empty),
    .o_level (o_level)
  );
  assign s.o_ready = !full;
  assign o_txd = txd_q;
  assign o_busy = busy_q;
  assign bit_end = baud_q == div_q - DIV_WD'(1);
  assign parity_on = par_q == PAR_ODD || par_q == PAR_EVEN;
  always_comb begin
    state_d = state_q;
    baud_d = bit_end ? '0 : baud_q + DIV_WD'(1);
    bit_d = bit_q;
    shift_d = shift_q;
    div_d = div_q;
    par_d = par_q;
    pbit_d = pbit_q;
    pop = 1'b0;
    case (state_q)
      S_IDLE: pop = !empty;
      S_START: if (bit_end) state_d = S_DATA;
      S_DATA: if (bit_end) begin
        shift_d = shift_q >> 1;
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(DATA_BIT - 1)) begin
          state_d = parity_on ? S_PARITY : S_STOP;
          bit_d = '0;
        end
      end
      S_PARITY: if (bit_end) state_d = S_STOP;
      S_STOP: if (bit_end) begin
        bit_d = bit_q + BW'(1);
        if (bit_q == BW'(STOP_BIT - 1)) begin
          state_d = S_IDLE;
          pop = !empty;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // a pop starts a frame and latches its per-frame settings
    if (pop) begin
      state_d = S_START;
      baud_d = '0;
      bit_d = '0;
      shift_d = fifo_data;
      div_d = (i_div < DIV_WD'(2)) ? DIV_WD'(2) : i_div;
      par_d = i_parity;
      pbit_d = (i_parity == PAR_ODD) ? ~^fifo_data : ^fifo_data;
    end
    txd_d = (state_d == S_START) ? 1'b0 :
            (state_d == S_DATA) ? shift_d[0] :
            (state_d == S_PARITY) ? pbit_d : 1'b1;
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q <= S_IDLE;
      baud_q <= '0;
      bit_q <= '0;
      shift_q <= '0;
      div_q <= DIV_WD'(2);
      par_q <= PAR_NONE;
      pbit_q <= 1'b0;
      txd_q <= 1'b1;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q <= baud_d;
      bit_q <= bit_d;
      shift_q <= shift_d;
      div_q <= div_d;
      par_q <= par_d;
      pbit_q <= pbit_d;
      txd_q <= txd_d;
      busy_q <= state_d != S_IDLE;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: directed and randomized frames against a bit-list reference model
module tb_uart_tx_fifo;
  import uart_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [15:0] i_div = 16'd4;
  logic [1:0] i_parity = 2'd0;
  logic txd1, busy1, txd2, busy2;
  logic [4:0] level1, level2;
  int errors = 0;
  int checks = 0;
  uart_tx_fifo_if #(.DATA_BIT(8)) bus1 ();
  uart_tx_fifo_if #(.DATA_BIT(8)) bus2 ();
  uart_tx_fifo #(.STOP_BIT(1)) dut (
    .i_clk(clk), .i_reset(rst), .s(bus1), .i_div(i_div), .i_parity(i_parity),
    .o_txd(txd1), .o_busy(busy1), .o_level(level1)
  );
  uart_tx_fifo #(.STOP_BIT(2)) dut2 (
    .i_clk(clk), .i_reset(rst), .s(bus2), .i_div(i_div), .i_parity(i_parity),
    .o_txd(txd2), .o_busy(busy2), .o_level(level2)
  );
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic txd_of(input int u);
    return (u == 1) ? txd2 : txd1;
  endfunction

  function automatic logic busy_of(input int u);
    return (u == 1) ? busy2 : busy1;
  endfunction

  function automatic int eff(input int d);
    return d < 2 ? 2 : d;
  endfunction

  task automatic push1(input int u, input logic [7:0] w);
    if (u == 1) begin
      bus2.i_data = w;
      bus2.i_valid = 1'b1;
    end else begin
      bus1.i_data = w;
      bus1.i_valid = 1'b1;
    end
    @(negedge clk);
    bus1.i_valid = 1'b0;
    bus2.i_valid = 1'b0;
  endtask

  // expected line: start 0, data LSB first, parity making the ones count odd/even, stop 1s
  task automatic check_frame(input int u, input logic [7:0] w, input int dv, input int pm,
                             input int nstop, output int gap, output int blen);
    logic bits[$];
    logic bad;
    bit first;
    int ones;
    gap = 0;
    blen = 0;
    while (txd_of(u) !== 1'b0 && gap < 400) begin
      @(negedge clk);
      gap++;
    end
    chk("frame_start_seen", 32'(gap < 400), 1);
    ones = $countones(w);
    bits.push_back(1'b0);
    for (int i = 0; i < 8; i++) bits.push_back(w[i]);
    if (pm == 1) bits.push_back(ones % 2 == 0);
    else if (pm == 2) bits.push_back(ones % 2 == 1);
    for (int i = 0; i < nstop; i++) bits.push_back(1'b1);
    first = 1'b1;
    foreach (bits[b]) begin
      bad = bits[b];
      for (int c = 0; c < dv; c++) begin
        if (!first) @(negedge clk);
        first = 1'b0;
        if (txd_of(u) !== bits[b]) bad = txd_of(u);
        if (busy_of(u) === 1'b1) blen++;
      end
      chk($sformatf("u%0d_w%02h_bit%0d", u, w, b), 32'(bad), 32'(bits[b]));
    end
    chk("frame_busy_len", blen, bits.size() * dv);
    @(negedge clk);
  endtask

  initial begin
    int gap, blen, acc_cnt, waitn, d, p;
    bit seen_full, acc;
    logic ok;
    logic [7:0] w, w0, w1;
    logic [7:0] words [20];
    bus1.i_valid = 1'b0;
    bus1.i_data = '0;
    bus2.i_valid = 1'b0;
    bus2.i_data = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_txd", 32'(txd1), 1);
    chk("rst_busy", 32'(busy1), 0);
    chk("rst_ready", 32'(bus1.o_ready), 1);
    chk("rst_level", 32'(level1), 0);
    @(negedge clk);
    i_div = 16'd4;
    i_parity = PAR_NONE;
    push1(0, 8'h55);
    chk("lat_level", 32'(level1), 1);
    chk("lat_txd", 32'(txd1), 1);
    chk("lat_busy", 32'(busy1), 0);
    @(negedge clk);
    chk("start_txd", 32'(txd1), 0);
    chk("start_busy", 32'(busy1), 1);
    chk("start_level", 32'(level1), 0);
    check_frame(0, 8'h55, 4, 0, 1, gap, blen);
    chk("basic_gap", gap, 0);
    chk("basic_busy_len", blen, 40);
    chk("basic_end_busy", 32'(busy1), 0);
    chk("basic_end_txd", 32'(txd1), 1);
    i_div = 16'd3;
    i_parity = PAR_ODD;
    push1(0, 8'h03);
    check_frame(0, 8'h03, 3, 1, 1, gap, blen);
    i_parity = PAR_EVEN;
    push1(0, 8'h07);
    check_frame(0, 8'h07, 3, 2, 1, gap, blen);
    push1(0, 8'h00);
    check_frame(0, 8'h00, 3, 2, 1, gap, blen);
    i_parity = 2'd3;
    push1(0, 8'hA5);
    check_frame(0, 8'hA5, 3, 3, 1, gap, blen);
    i_parity = PAR_ODD;
    w = 8'($urandom);
    push1(1, w);
    check_frame(1, w, 3, 1, 2, gap, blen);
    chk("stop2_frame_len", blen, 12 * 3);
    i_div = 16'd4;
    i_parity = PAR_NONE;
    w0 = 8'($urandom);
    w1 = 8'($urandom);
    fork
      begin
        bus1.i_data = w0;
        bus1.i_valid = 1'b1;
        @(negedge clk);
        bus1.i_data = w1;
        @(negedge clk);
        bus1.i_valid = 1'b0;
        repeat (10) @(negedge clk);
        i_div = 16'd8;
      end
      begin
        check_frame(0, w0, 4, 0, 1, gap, blen);
        check_frame(0, w1, 8, 0, 1, gap, blen);
        chk("div_change_gap", gap, 0);
      end
    join
    for (int k = 0; k < 2; k++) begin
      i_div = 16'(k);
      w = 8'($urandom);
      push1(0, w);
      check_frame(0, w, 2, 0, 1, gap, blen);
    end
    for (int k = 0; k < 6; k++) begin
      d = $urandom_range(0, 6);
      p = $urandom_range(0, 3);
      w = 8'($urandom);
      i_div = 16'(d);
      i_parity = 2'(p);
      push1(0, w);
      check_frame(0, w, eff(d), p, 1, gap, blen);
    end
    i_div = 16'd2;
    i_parity = PAR_NONE;
    for (int i = 0; i < 20; i++) words[i] = 8'($urandom);
    acc_cnt = 0;
    seen_full = 1'b0;
    waitn = 0;
    fork
      begin
        for (int i = 0; i < 20 && waitn < 400; i++) begin
          bus1.i_data = words[i];
          bus1.i_valid = 1'b1;
          waitn = 0;
          acc = 1'b0;
          while (!acc && waitn < 400) begin
            acc = bus1.o_ready;
            if (!acc) seen_full = 1'b1;
            @(negedge clk);
            waitn++;
          end
          if (acc && !seen_full) acc_cnt++;
        end
        bus1.i_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 20; i++) begin
          check_frame(0, words[i], 2, 0, 1, gap, blen);
          if (i > 0) chk($sformatf("burst_gap%0d", i), gap, 0);
        end
      end
    join
    chk("burst_push_bound", 32'(waitn < 400), 1);
    chk("burst_accepted_before_full", acc_cnt, 17);
    chk("burst_end_level", 32'(level1), 0);
    chk("burst_end_busy", 32'(busy1), 0);
    i_div = 16'd4;
    push1(0, 8'h00);
    push1(0, 8'hAA);
    push1(0, 8'hBB);
    push1(0, 8'hCC);
    repeat (4) @(negedge clk);
    chk("pre_reset_level", 32'(level1), 3);
    chk("pre_reset_txd", 32'(txd1), 0);
    #2 rst = 1'b1;
    #1;
    chk("async_reset_txd", 32'(txd1), 1);
    chk("async_reset_level", 32'(level1), 0);
    chk("async_reset_busy", 32'(busy1), 0);
    chk("async_reset_ready", 32'(bus1.o_ready), 1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    ok = 1'b1;
    repeat (60) begin
      @(negedge clk);
      if (txd1 !== 1'b1 || busy1 !== 1'b0 || level1 !== 5'd0) ok = 1'b0;
    end
    chk("post_reset_quiet", 32'(ok), 1);
    w = 8'hC3;
    push1(0, w);
    check_frame(0, w, 4, 0, 1, gap, blen);
    chk("post_reset_gap", gap, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
